// File: rtl/path_backtrace.sv
// path_backtrace
//   Walks the predecessor links held in the vertex / prev_vertex / dist_from_prev
//   discard memories, from target back to source, and streams the path (target
//   first) over a valid/ready port while accumulating the total path length.
// Ports
//   clk, rst_n                 clock, async active-low reset
//   start                      begin a walk (only honoured in IDLE)
//   source_vertex/target_vertex/discard_count   walk arguments, latched on start
//   disc_addr                  shared read address to the three discard memories
//   vertex_q/prev_q/dist_q     1-cycle registered read data
//   busy/done/error            status; done/error are one-cycle pulses
//   path_valid/ready/vertex/dist/last   path beat stream
//   total_dist                 saturating sum of emitted path_dist
module path_backtrace #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int SUM_W  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] source_vertex,
  input  logic [DATA_W-1:0] target_vertex,
  input  logic [ADDR_W-1:0] discard_count,
  output logic [ADDR_W-1:0] disc_addr,
  input  logic [DATA_W-1:0] vertex_q,
  input  logic [DATA_W-1:0] prev_q,
  input  logic [DATA_W-1:0] dist_q,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              path_valid,
  input  logic              path_ready,
  output logic [DATA_W-1:0] path_vertex,
  output logic [DATA_W-1:0] path_dist,
  output logic              path_last,
  output logic [SUM_W-1:0]  total_dist
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_CMP, S_EMIT, S_FIN, S_ERR
  } state_t;

  localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t state, nxt;

  logic [DATA_W-1:0] src, cur, prv;
  // One extra bit on the index: the MSB goes high once the scan steps below
  // entry 0 (including count==0), which is the "no entries left" condition.
  logic [ADDR_W:0]   idx;
  logic              idx_uf;
  logic              hit;
  logic              hs;
  logic [SUM_W:0]    sum_ext;

  assign idx_uf  = idx[ADDR_W];
  assign hit     = (vertex_q == cur);
  assign hs      = (state == S_EMIT) && path_ready;
  assign sum_ext = {1'b0, total_dist} + {{(SUM_W+1-DATA_W){1'b0}}, path_dist};

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  // next-state logic
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (start) nxt = S_CHECK;
      S_CHECK: begin
        if (cur == src)  nxt = S_EMIT;
        else if (idx_uf) nxt = S_ERR;
        else             nxt = S_ISSUE;
      end
      S_ISSUE: nxt = S_WAIT;
      S_WAIT:  nxt = S_CMP;
      S_CMP:   nxt = hit ? S_EMIT : S_CHECK;
      S_EMIT:  if (path_ready) nxt = path_last ? S_FIN : S_CHECK;
      S_FIN:   nxt = S_IDLE;
      S_ERR:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    path_valid = 1'b0;
    case (state)
      S_CHECK, S_ISSUE, S_WAIT, S_CMP: busy = 1'b1;
      S_EMIT: begin
        busy       = 1'b1;
        path_valid = 1'b1;
      end
      S_FIN:   done  = 1'b1;
      S_ERR:   error = 1'b1;
      default: ;
    endcase
  end

  // datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src         <= '0;
      cur         <= '0;
      prv         <= '0;
      idx         <= '0;
      disc_addr   <= '0;
      path_vertex <= '0;
      path_dist   <= '0;
      path_last   <= 1'b0;
      total_dist  <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          src        <= source_vertex;
          cur        <= target_vertex;
          idx        <= {1'b0, discard_count} - IDX_ONE;
          total_dist <= '0;
        end
        S_CHECK: begin
          if (cur == src) begin
            // source reached without a memory probe
            path_vertex <= cur;
            path_dist   <= '0;
            path_last   <= 1'b1;
          end else if (!idx_uf) begin
            disc_addr <= idx[ADDR_W-1:0];
          end
        end
        S_CMP: begin
          if (hit) begin
            path_vertex <= cur;
            path_dist   <= dist_q;
            path_last   <= 1'b0;
            prv         <= prev_q;
          end else begin
            idx <= idx - IDX_ONE;
          end
        end
        S_EMIT: if (hs) begin
          total_dist <= sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
          // predecessor always lives at a lower index than the current hit
          if (!path_last) begin
            cur <= prv;
            idx <= idx - IDX_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
